// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 Y address arithmetic unit: register
// select codes, fixed-step codes, data width and the short-immediate extender.
package jtdsp16_pkg;

  localparam int DW = 16;

  // Register-file select codes (r_field)
  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] J  = 3'd4;
  localparam logic [2:0] K  = 3'd5;
  localparam logic [2:0] RB = 3'd6;
  localparam logic [2:0] RE = 3'd7;

  // Fixed-step codes (inc_sel); code 3 is a reserved alias of +1
  localparam logic [1:0] INC_0   = 2'd0;
  localparam logic [1:0] INC_P1  = 2'd1;
  localparam logic [1:0] INC_M1  = 2'd2;
  localparam logic [1:0] INC_P1R = 2'd3;

  // Step registers hold signed offsets, so they take the sign of the 9-bit
  // immediate; pointers and bounds are plain addresses and are zero-extended.
  function automatic logic [DW-1:0] extendShort(input logic [8:0] imm, input logic [2:0] tgt);
    if (tgt == J || tgt == K) begin
      return {{(DW-9){imm[8]}}, imm};
    end
    return {{(DW-9){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/jtdsp16_yaau_step.sv
// Next-pointer computation for a post-modify: picks the step (j/k or a fixed
// +1/-1/0), adds it modulo 2^16 and applies the rb/re circular wrap.
module jtdsp16_yaau_step
  import jtdsp16_pkg::*;
#(
  parameter bit CIRC_EN = 1'b1
) (
  input  logic [DW-1:0] pointer,
  input  logic [DW-1:0] j,
  input  logic [DW-1:0] k,
  input  logic [DW-1:0] rb,
  input  logic [DW-1:0] re,
  input  logic [1:0]    inc_sel,
  input  logic          step_sel,
  input  logic          ksel,
  output logic [DW-1:0] next_ptr
);

  logic [DW-1:0] w_step;
  logic          w_wrap;

  // Select the step amount; -1 is all ones so the modulo add subtracts
  always_comb begin
    w_step = '0;
    if (step_sel) begin
      w_step = ksel ? k : j;
    end else begin
      case (inc_sel)
        INC_P1, INC_P1R: w_step = DW'(1);
        INC_M1:          w_step = '1;
        default:         w_step = '0;
      endcase
    end
  end

  // Only the explicit +1 code wraps, and only when a non-zero end bound is set
  assign w_wrap   = CIRC_EN && (re != '0) && !step_sel && (inc_sel == INC_P1) && (pointer == re);
  assign next_ptr = w_wrap ? rb : pointer + w_step;

endmodule

// File: rtl/jtdsp16_yaau.sv
// Y address arithmetic unit: eight-entry register file (r0-r3, j, k, rb, re),
// direct and delayed-RAM loads, pointer post-modify and the registered
// Y data-RAM address.
module jtdsp16_yaau
  import jtdsp16_pkg::*;
#(
  parameter bit CIRC_EN = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic [2:0]    r_field,
  input  logic [1:0]    y_field,
  input  logic [1:0]    inc_sel,
  input  logic          ksel,
  input  logic          step_sel,
  input  logic          short_load,
  input  logic          long_load,
  input  logic          acc_load,
  input  logic          ram_load,
  input  logic          post_load,
  input  logic [8:0]    short_imm,
  input  logic [15:0]   long_imm,
  input  logic [15:0]   acc_dout,
  input  logic [15:0]   ram_dout,
  output logic [15:0]   ram_addr,
  output logic [15:0]   reg_dout,
  output logic          ram_pend
);

  logic [DW-1:0] r_regs [0:7];
  logic [DW-1:0] r_ramAddr;
  logic          r_ramPend;
  logic [2:0]    r_pendTgt;

  logic [2:0]    w_ySel;
  logic [DW-1:0] w_ptr;
  logic [DW-1:0] w_nextPtr;
  logic          w_directLoad;
  logic [DW-1:0] w_loadVal;

  assign w_ySel       = {1'b0, y_field};
  assign w_ptr        = r_regs[w_ySel];
  assign w_directLoad = short_load | long_load | acc_load;

  // Direct-load data with short > long > acc priority
  always_comb begin
    w_loadVal = acc_dout;
    if (short_load) begin
      w_loadVal = extendShort(short_imm, r_field);
    end else if (long_load) begin
      w_loadVal = long_imm;
    end
  end

  jtdsp16_yaau_step #(
    .CIRC_EN (CIRC_EN)
  ) u_step (
    .pointer  (w_ptr),
    .j        (r_regs[J]),
    .k        (r_regs[K]),
    .rb       (r_regs[RB]),
    .re       (r_regs[RE]),
    .inc_sel  (inc_sel),
    .step_sel (step_sel),
    .ksel     (ksel),
    .next_ptr (w_nextPtr)
  );

  // Register file update; later writes override earlier ones, giving direct > RAM > post-modify
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
      r_ramAddr <= '0;
      r_ramPend <= 1'b0;
      r_pendTgt <= R0;
    end else if (cen) begin
      if (post_load) begin
        r_ramAddr      <= w_ptr;
        r_regs[w_ySel] <= w_nextPtr;
      end
      if (r_ramPend) begin
        r_regs[r_pendTgt] <= ram_dout;
      end
      if (w_directLoad) begin
        r_regs[r_field] <= w_loadVal;
      end
      r_ramPend <= ram_load;
      if (ram_load) begin
        r_pendTgt <= r_field;
      end
    end
  end

  assign ram_addr = r_ramAddr;
  assign ram_pend = r_ramPend;
  assign reg_dout = r_regs[r_field];

endmodule

// File: tb/tb_jtdsp16_yaau.sv
// Self-checking bench for jtdsp16_yaau: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_jtdsp16_yaau;

  logic        rst = 1'b0;
  logic        clk = 1'b0;
  logic        cen = 1'b0;
  logic [2:0]  r_field = '0;
  logic [1:0]  y_field = '0;
  logic [1:0]  inc_sel = '0;
  logic        ksel = 1'b0;
  logic        step_sel = 1'b0;
  logic        short_load = 1'b0;
  logic        long_load = 1'b0;
  logic        acc_load = 1'b0;
  logic        ram_load = 1'b0;
  logic        post_load = 1'b0;
  logic [8:0]  short_imm = '0;
  logic [15:0] long_imm = '0;
  logic [15:0] acc_dout = '0;
  logic [15:0] ram_dout = '0;
  logic [15:0] ram_addr;
  logic [15:0] reg_dout;
  logic        ram_pend;

  jtdsp16_yaau #(
    .CIRC_EN (1'b1)
  ) dut (
    .rst        (rst),
    .clk        (clk),
    .cen        (cen),
    .r_field    (r_field),
    .y_field    (y_field),
    .inc_sel    (inc_sel),
    .ksel       (ksel),
    .step_sel   (step_sel),
    .short_load (short_load),
    .long_load  (long_load),
    .acc_load   (acc_load),
    .ram_load   (ram_load),
    .post_load  (post_load),
    .short_imm  (short_imm),
    .long_imm   (long_imm),
    .acc_dout   (acc_dout),
    .ram_dout   (ram_dout),
    .ram_addr   (ram_addr),
    .reg_dout   (reg_dout),
    .ram_pend   (ram_pend)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit compareOn = 1'b0;

  logic [15:0] mRegs [8];
  logic [15:0] mAddr;
  logic        mPend;
  int          mTgt;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Pointer after a post-modify, computed with integer arithmetic
  function automatic logic [15:0] modelPost(input logic [15:0] ptr);
    int s;
    if (step_sel) begin
      s = ksel ? int'($signed(mRegs[5])) : int'($signed(mRegs[4]));
    end else if (inc_sel == 2'd2) begin
      s = -1;
    end else if (inc_sel == 2'd0) begin
      s = 0;
    end else begin
      s = 1;
    end
    if (!step_sel && inc_sel == 2'd1 && mRegs[7] != 16'h0 && ptr == mRegs[7]) begin
      return mRegs[6];
    end
    return 16'((int'(ptr) + s) & 32'hFFFF);
  endfunction

  // New value of register idx: the highest-priority writer targeting it wins
  function automatic logic [15:0] modelWrite(input int idx);
    int sv;
    if ((short_load || long_load || acc_load) && int'(r_field) == idx) begin
      if (short_load) begin
        sv = int'(short_imm);
        if ((idx == 4 || idx == 5) && sv >= 256) sv = sv - 512;
        return 16'(sv & 32'hFFFF);
      end
      return long_load ? long_imm : acc_dout;
    end
    if (mPend && mTgt == idx) return ram_dout;
    if (post_load && int'(y_field) == idx) return modelPost(mRegs[idx]);
    return mRegs[idx];
  endfunction

  // Behavioural reference state
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mRegs[i] <= 16'h0;
      mAddr <= 16'h0;
      mPend <= 1'b0;
      mTgt  <= 0;
    end else if (cen) begin
      for (int i = 0; i < 8; i++) mRegs[i] <= modelWrite(i);
      if (post_load) mAddr <= mRegs[y_field];
      mPend <= ram_load;
      if (ram_load) mTgt <= int'(r_field);
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("cmp_ram_addr", ram_addr, mAddr);
      checkOutput("cmp_ram_pend", {15'h0, ram_pend}, {15'h0, mPend});
      checkOutput("cmp_reg_dout", reg_dout, mRegs[r_field]);
    end
  end

  task automatic setIdle();
    cen = 1'b1; short_load = 1'b0; long_load = 1'b0; acc_load = 1'b0;
    ram_load = 1'b0; post_load = 1'b0; step_sel = 1'b0; ksel = 1'b0; inc_sel = 2'd0;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    #1;
  endtask

  task automatic readReg(input logic [2:0] tgt, input logic [15:0] exp, input string name);
    setIdle();
    r_field = tgt;
    #1;
    checkOutput(name, reg_dout, exp);
  endtask

  task automatic loadLong(input logic [2:0] tgt, input logic [15:0] v);
    setIdle();
    r_field = tgt; long_load = 1'b1; long_imm = v;
    applyStimulus();
    setIdle();
  endtask

  task automatic postMod(input logic [1:0] y, input logic [1:0] inc, input logic ss, input logic ks);
    setIdle();
    y_field = y; inc_sel = inc; step_sel = ss; ksel = ks; post_load = 1'b1;
    applyStimulus();
    setIdle();
  endtask

  logic [15:0] wrapAddr [3] = '{16'h0011, 16'h0012, 16'h0010};

  // Directed scenarios, then randomized traffic
  initial begin
    setIdle();
    #1 rst = 1'b1;
    applyStimulus();
    compareOn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      readReg(3'(i), 16'h0, "reset_reg");
      applyStimulus();
    end
    checkOutput("reset_ram_addr", ram_addr, 16'h0);
    checkOutput("reset_ram_pend", {15'h0, ram_pend}, 16'h0);
    rst = 1'b0;
    applyStimulus();

    setIdle(); r_field = 3'd4; short_load = 1'b1; short_imm = 9'h1FD;
    applyStimulus();
    readReg(3'd4, 16'hFFFD, "short_j_sext");
    r_field = 3'd6; short_load = 1'b1; short_imm = 9'h1FD;
    applyStimulus();
    readReg(3'd6, 16'h01FD, "short_rb_zext");

    loadLong(3'd6, 16'h0010);
    loadLong(3'd7, 16'h0012);
    loadLong(3'd0, 16'h0011);
    for (int n = 0; n < 3; n++) begin
      postMod(2'd0, 2'd1, 1'b0, 1'b0);
      checkOutput("wrap_ram_addr", ram_addr, wrapAddr[n]);
    end
    readReg(3'd0, 16'h0011, "wrap_r0_final");

    loadLong(3'd1, 16'h0005);
    postMod(2'd1, 2'd0, 1'b1, 1'b0);
    checkOutput("jstep_ram_addr", ram_addr, 16'h0005);
    readReg(3'd1, 16'h0002, "jstep_r1");
    loadLong(3'd7, 16'h0002);
    postMod(2'd1, 2'd0, 1'b1, 1'b0);
    checkOutput("jstep_nowrap_addr", ram_addr, 16'h0002);
    readReg(3'd1, 16'hFFFF, "jstep_nowrap_r1");

    setIdle(); r_field = 3'd2; ram_load = 1'b1;
    applyStimulus();
    checkOutput("ramload_pend_set", {15'h0, ram_pend}, 16'h1);
    setIdle(); ram_dout = 16'hBEEF;
    applyStimulus();
    checkOutput("ramload_pend_clr", {15'h0, ram_pend}, 16'h0);
    readReg(3'd2, 16'hBEEF, "ramload_r2");
    setIdle(); r_field = 3'd2; ram_load = 1'b1;
    applyStimulus();
    setIdle(); r_field = 3'd2; long_load = 1'b1; long_imm = 16'h1234; ram_dout = 16'h5555;
    applyStimulus();
    readReg(3'd2, 16'h1234, "conflict_direct_wins");

    setIdle(); r_field = 3'd3; ram_load = 1'b1;
    applyStimulus();
    setIdle(); cen = 1'b0; r_field = 3'd3; short_load = 1'b1; short_imm = 9'h055;
    for (int n = 0; n < 3; n++) begin
      ram_dout = 16'($urandom);
      applyStimulus();
    end
    checkOutput("gate_pend_held", {15'h0, ram_pend}, 16'h1);
    readReg(3'd3, 16'h0000, "gate_r3_held");
    ram_dout = 16'h00AA;
    applyStimulus();
    readReg(3'd3, 16'h00AA, "gate_r3_written");
    checkOutput("gate_pend_clr", {15'h0, ram_pend}, 16'h0);

    setIdle(); r_field = 3'd1; ram_load = 1'b1;
    applyStimulus();
    checkOutput("midrst_pend_before", {15'h0, ram_pend}, 16'h1);
    setIdle();
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_pend", {15'h0, ram_pend}, 16'h0);
    checkOutput("midrst_ram_addr", ram_addr, 16'h0);
    ram_dout = 16'h7777;
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    readReg(3'd1, 16'h0000, "midrst_no_write");

    for (int n = 0; n < 3000; n++) begin
      cen        = ($urandom_range(0, 3) != 0);
      short_load = ($urandom_range(0, 7) == 0);
      long_load  = ($urandom_range(0, 5) == 0);
      acc_load   = ($urandom_range(0, 7) == 0);
      ram_load   = ($urandom_range(0, 3) == 0);
      post_load  = ($urandom_range(0, 1) == 0);
      r_field    = 3'($urandom);
      y_field    = 2'($urandom);
      inc_sel    = 2'($urandom);
      ksel       = 1'($urandom);
      step_sel   = 1'($urandom);
      short_imm  = 9'($urandom);
      long_imm   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      acc_dout   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      ram_dout   = 16'($urandom);
      rst        = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    rst = 1'b0;
    setIdle();
    applyStimulus();
    compareOn = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
